// File: rtl/decode_issue_ctrl_pkg.sv
// Shared definitions for the decode/issue controller: opcodes, the NOP word,
// the load-count type and the derived issue-state encoding.
package decode_issue_ctrl_pkg;

    localparam logic [6:0]  OPCODE_I_LOAD = 7'b0000011;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

    // Wide enough for the largest supported MAX_LOADS (7)
    localparam int unsigned LD_CNT_W = 3;
    typedef logic [LD_CNT_W-1:0] ld_cnt_t;

    // Issue state is decoded from id_valid and hazard; it owns no flops
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HELD   = 2'd1,
        ST_HAZARD = 2'd2
    } issue_state_t;

    // One-hot mask for an architectural register number
    function automatic logic [31:0] reg_bit(input logic [4:0] r);
        return 32'h1 << r;
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Bus bundle between the issue controller and its fetch/decoder/EX neighbours.
// Optional macro ISSUE_PERF_CNT_EN adds the perf_stall_cnt/perf_issue_cnt outputs.
interface decode_issue_ctrl_if #(
    parameter int unsigned PC_W = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     dec_instr;
    logic [6:0]      dec_opcode;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_r;
    logic            dec_i;
    logic            dec_s;
    logic            dec_b;
    logic            dec_u;
    logic            dec_j;
    logic            ex_valid;
    logic            ex_ready;
    logic [31:0]     ex_instr;
    logic [PC_W-1:0] ex_pc;
    logic            ex_illegal;
    logic            flush;
    logic            ld_done;
    logic [4:0]      ld_rd;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_issue_cnt;
`endif

    // Controller side
    modport slave (
`ifdef ISSUE_PERF_CNT_EN
        output perf_stall_cnt, perf_issue_cnt,
`endif
        input  if_valid, if_instr, if_pc,
        input  dec_opcode, dec_rs1, dec_rs2, dec_rd,
        input  dec_r, dec_i, dec_s, dec_b, dec_u, dec_j,
        input  ex_ready, flush, ld_done, ld_rd,
        output if_ready, dec_instr, ex_valid, ex_instr, ex_pc, ex_illegal
    );

    // Environment side (fetch, decoder, EX)
    modport master (
`ifdef ISSUE_PERF_CNT_EN
        input  perf_stall_cnt, perf_issue_cnt,
`endif
        output if_valid, if_instr, if_pc,
        output dec_opcode, dec_rs1, dec_rs2, dec_rd,
        output dec_r, dec_i, dec_s, dec_b, dec_u, dec_j,
        output ex_ready, flush, ld_done, ld_rd,
        input  if_ready, dec_instr, ex_valid, ex_instr, ex_pc, ex_illegal
    );

endinterface

// File: rtl/decode_issue_ctrl_load_scoreboard.sv
// Outstanding-load tracker: pending-destination mask, load counter and the
// load-use / load-capacity hazard for the instruction sitting in IF/ID.
module load_scoreboard
    import decode_issue_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LOADS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       src1_use_i,
    input  logic       src2_use_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    input  logic       load_i,
    input  logic       fire_i,
    input  logic       ld_done_i,
    input  logic [4:0] ld_rd_i,
    output logic       hazard_o
);

    localparam ld_cnt_t MAX_CNT = ld_cnt_t'(MAX_LOADS);

    logic [31:0] pending_q, pending_d;
    ld_cnt_t     cnt_q, cnt_d;
    logic [31:0] clr_mask;
    logic [31:0] live_mask;

    // Write-back clear is applied before the hazard check so a load finishing
    // this cycle releases its consumer in the same cycle
    always_comb begin
        clr_mask  = ld_done_i ? reg_bit(ld_rd_i) : '0;
        live_mask = pending_q & ~clr_mask;
        hazard_o  = (src1_use_i && (rs1_i != 5'd0) && live_mask[rs1_i])
                 || (src2_use_i && (rs2_i != 5'd0) && live_mask[rs2_i])
                 || (load_i && (cnt_q == MAX_CNT) && !ld_done_i);
    end

    // Next mask and count; a set on the same register as a clear wins
    always_comb begin
        logic inc;
        logic dec;
        pending_d = live_mask;
        if (fire_i && load_i && (rd_i != 5'd0)) begin
            pending_d = pending_d | reg_bit(rd_i);
        end
        inc   = fire_i && load_i;
        dec   = ld_done_i && (cnt_q != '0);
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + ld_cnt_t'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - ld_cnt_t'(1);
        end
    end

    // Scoreboard state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: IF/ID register, fetch and EX handshakes, flush
// squash, and load-use stalling via the load_scoreboard sub-module.
// Optional macro ISSUE_PERF_CNT_EN adds stall/issue performance counters.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LOADS = 2,
    parameter int unsigned PC_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_issue_ctrl_if.slave   bus
);

    logic            id_valid_q, id_valid_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d;

    logic         any_flag;
    logic         src1_use;
    logic         src2_use;
    logic         load_op;
    logic         hazard;
    logic         ex_valid;
    logic         ex_fire;
    logic         if_ready;
    logic         capture;
    issue_state_t state;

    // Decoder feedback is qualified by id_valid so an empty slot never hazards
    assign any_flag = bus.dec_r | bus.dec_i | bus.dec_s | bus.dec_b | bus.dec_u | bus.dec_j;
    assign src1_use = id_valid_q && (bus.dec_r | bus.dec_i | bus.dec_s | bus.dec_b);
    assign src2_use = id_valid_q && (bus.dec_r | bus.dec_s | bus.dec_b);
    assign load_op  = id_valid_q && any_flag && (bus.dec_opcode == OPCODE_I_LOAD);

    load_scoreboard #(
        .MAX_LOADS (MAX_LOADS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .src1_use_i (src1_use),
        .src2_use_i (src2_use),
        .rs1_i      (bus.dec_rs1),
        .rs2_i      (bus.dec_rs2),
        .rd_i       (bus.dec_rd),
        .load_i     (load_op),
        .fire_i     (ex_fire),
        .ld_done_i  (bus.ld_done),
        .ld_rd_i    (bus.ld_rd),
        .hazard_o   (hazard)
    );

    // Derived state, handshakes and IF/ID next-state
    always_comb begin
        state = ST_EMPTY;
        if (id_valid_q) begin
            state = hazard ? ST_HAZARD : ST_HELD;
        end
        ex_valid   = (state == ST_HELD) && !bus.flush;
        ex_fire    = ex_valid && bus.ex_ready;
        if_ready   = (state == ST_EMPTY) || ex_fire || bus.flush;
        capture    = bus.if_valid && if_ready && !bus.flush;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (bus.flush) begin
            id_valid_d = 1'b0;
        end else if (capture) begin
            id_valid_d = 1'b1;
            id_instr_d = bus.if_instr;
            id_pc_d    = bus.if_pc;
        end else if (ex_fire) begin
            id_valid_d = 1'b0;
        end
    end

    // IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    assign bus.if_ready   = if_ready;
    assign bus.dec_instr  = id_instr_q;
    assign bus.ex_valid   = ex_valid;
    assign bus.ex_instr   = id_instr_q;
    assign bus.ex_pc      = id_pc_q;
    assign bus.ex_illegal = id_valid_q && !any_flag;

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_issue_q;

    // Stall and issue counters, frozen during flush, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_issue_q <= '0;
        end else if (!bus.flush) begin
            if (state == ST_HAZARD) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (ex_fire) begin
                perf_issue_q <= perf_issue_q + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = perf_stall_q;
    assign bus.perf_issue_cnt = perf_issue_q;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: a behavioural decoder, an issue
// scoreboard of expected EX transfers, and per-scenario directed tasks.
module tb_decode_issue_ctrl;
    import decode_issue_ctrl_pkg::*;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned MAX_LOADS = 2;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_issue_ctrl_if #(.PC_W(PC_W)) bus();

    decode_issue_ctrl #(
        .MAX_LOADS (MAX_LOADS),
        .PC_W      (PC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t expq[$];
    exp_t mon_e;

    // Behavioural RV32 decoder fed by dec_instr
    always_comb begin
        bus.dec_opcode = bus.dec_instr[6:0];
        bus.dec_rd     = bus.dec_instr[11:7];
        bus.dec_rs1    = bus.dec_instr[19:15];
        bus.dec_rs2    = bus.dec_instr[24:20];
        bus.dec_r = 1'b0; bus.dec_i = 1'b0; bus.dec_s = 1'b0;
        bus.dec_b = 1'b0; bus.dec_u = 1'b0; bus.dec_j = 1'b0;
        case (bus.dec_instr[6:0])
            7'b0110011:                                     bus.dec_r = 1'b1;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: bus.dec_i = 1'b1;
            7'b0100011:                                     bus.dec_s = 1'b1;
            7'b1100011:                                     bus.dec_b = 1'b1;
            7'b0110111, 7'b0010111:                         bus.dec_u = 1'b1;
            7'b1101111:                                     bus.dec_j = 1'b1;
            default: ;
        endcase
    end

    // Every EX transfer must match the next expected entry
    always @(negedge clk) begin
        if (!rst && bus.ex_valid && bus.ex_ready) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL issue_unexpected: got instr=%h pc=%h, required no issue", bus.ex_instr, bus.ex_pc);
            end else begin
                mon_e = expq.pop_front();
                if (bus.ex_instr !== mon_e.instr || bus.ex_pc !== mon_e.pc || bus.ex_illegal !== mon_e.ill) begin
                    miscompares++;
                    $display("FAIL issue: got instr=%h pc=%h ill=%b, required instr=%h pc=%h ill=%b",
                             bus.ex_instr, bus.ex_pc, bus.ex_illegal, mon_e.instr, mon_e.pc, mon_e.ill);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw_i(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'b0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic ill);
        exp_t e;
        e.instr = instr; e.pc = pc; e.ill = ill;
        expq.push_back(e);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid = 1'b1; bus.if_instr = instr; bus.if_pc = pc;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
        bus.ex_ready = 1'b1; bus.flush = 1'b0; bus.ld_done = 1'b0; bus.ld_rd = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #2;
        vectors++; if (bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL reset_if_ready: got %b, required 1", bus.if_ready); end
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ex_valid: got %b, required 0", bus.ex_valid); end
        vectors++; if (bus.dec_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_dec_instr: got %h, required 00000013", bus.dec_instr); end
        vectors++; if (bus.ex_pc !== 32'h0) begin miscompares++; $display("FAIL reset_ex_pc: got %h, required 0", bus.ex_pc); end
        vectors++; if (bus.ex_illegal !== 1'b0) begin miscompares++; $display("FAIL reset_ex_illegal: got %b, required 0", bus.ex_illegal); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                offer(add_i(5'(k + 1), 5'(k + 10), 5'(k + 20)), 32'(4 * k));
                push(add_i(5'(k + 1), 5'(k + 10), 5'(k + 20)), 32'(4 * k), 1'b0);
            end else begin
                bus.if_valid = 1'b0;
            end
            samp();
            vectors++; if (bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_if_ready[%0d]: got %b, required 1", k, bus.if_ready); end
            if (k > 0) begin
                vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_ex_valid[%0d]: got %b, required 1", k, bus.ex_valid); end
            end
            tick();
        end
        samp();
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got ex_valid=%b, required 0", bus.ex_valid); end
        tick();
    endtask

    task automatic test_load_use();
        apply_reset();
        offer(lw_i(5, 0), 32'h100); push(lw_i(5, 0), 32'h100, 1'b0);
        samp(); tick();
        offer(add_i(6, 5, 1), 32'h104); push(add_i(6, 5, 1), 32'h104, 1'b0);
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL lu_lw_issue: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        bus.if_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            samp();
            vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL lu_stall[%0d]: got ex_valid=%b, required 0", c, bus.ex_valid); end
            vectors++; if (bus.if_ready !== 1'b0) begin miscompares++; $display("FAIL lu_stall_if_ready[%0d]: got %b, required 0", c, bus.if_ready); end
            tick();
        end
        bus.ld_done = 1'b1; bus.ld_rd = 5'd5;
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL lu_bypass: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        bus.ld_done = 1'b0;
        samp();
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL lu_after: got ex_valid=%b, required 0", bus.ex_valid); end
        tick();
    endtask

    task automatic test_max_loads();
        apply_reset();
        offer(lw_i(1, 0), 32'h200); push(lw_i(1, 0), 32'h200, 1'b0);
        samp(); tick();
        offer(lw_i(2, 0), 32'h204); push(lw_i(2, 0), 32'h204, 1'b0);
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL ml_lw1: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        offer(lw_i(3, 0), 32'h208); push(lw_i(3, 0), 32'h208, 1'b0);
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL ml_lw2: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        bus.if_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            samp();
            vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL ml_full[%0d]: got ex_valid=%b, required 0", c, bus.ex_valid); end
            tick();
        end
        bus.ld_done = 1'b1; bus.ld_rd = 5'd1;
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL ml_release: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        bus.ld_done = 1'b0;
        offer(lw_i(4, 0), 32'h20C); push(lw_i(4, 0), 32'h20C, 1'b0);
        samp(); tick();
        bus.if_valid = 1'b0;
        samp();
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL ml_still_full: got ex_valid=%b, required 0", bus.ex_valid); end
        tick();
        bus.ld_done = 1'b1; bus.ld_rd = 5'd2;
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL ml_release2: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        // drain to zero, then one extra write-back that must be ignored
        bus.ld_rd = 5'd3; samp(); tick();
        bus.ld_rd = 5'd4; samp(); tick();
        bus.ld_rd = 5'd9; samp(); tick();
        bus.ld_done = 1'b0;
        offer(lw_i(7, 0), 32'h210); push(lw_i(7, 0), 32'h210, 1'b0);
        samp(); tick();
        offer(lw_i(8, 0), 32'h214); push(lw_i(8, 0), 32'h214, 1'b0);
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL ml_lw7: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        offer(lw_i(10, 0), 32'h218);
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL ml_lw8: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        bus.if_valid = 1'b0;
        samp();
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL ml_no_underflow: got ex_valid=%b, required 0", bus.ex_valid); end
        tick();
    endtask

    task automatic test_flush();
        apply_reset();
        bus.ex_ready = 1'b0;
        offer(add_i(1, 2, 3), 32'h300);
        samp(); tick();
        bus.flush = 1'b1; bus.ex_ready = 1'b1;
        offer(add_i(4, 5, 6), 32'h304);
        samp();
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL fl_ex_valid: got %b, required 0", bus.ex_valid); end
        vectors++; if (bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL fl_if_ready: got %b, required 1", bus.if_ready); end
        tick();
        bus.flush = 1'b0; bus.if_valid = 1'b0;
        samp();
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL fl_dropped: got ex_valid=%b, required 0", bus.ex_valid); end
        tick();
        offer(lw_i(9, 0), 32'h308); push(lw_i(9, 0), 32'h308, 1'b0);
        samp(); tick();
        offer(add_i(10, 9, 0), 32'h30C);
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL fl_lw_issue: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        bus.flush = 1'b1; bus.if_valid = 1'b0;
        samp(); tick();
        bus.flush = 1'b0;
        offer(add_i(11, 9, 0), 32'h310); push(add_i(11, 9, 0), 32'h310, 1'b0);
        samp(); tick();
        bus.if_valid = 1'b0;
        samp();
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL fl_sb_kept: got ex_valid=%b, required 0", bus.ex_valid); end
        tick();
        bus.ld_done = 1'b1; bus.ld_rd = 5'd9;
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL fl_release: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
        bus.ld_done = 1'b0;
    endtask

    task automatic test_stall();
        apply_reset();
        bus.ex_ready = 1'b0;
        offer(add_i(1, 2, 3), 32'h400); push(add_i(1, 2, 3), 32'h400, 1'b0);
        samp(); tick();
        offer(add_i(4, 5, 6), 32'h404);
        for (int c = 0; c < 3; c++) begin
            samp();
            vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL st_valid[%0d]: got %b, required 1", c, bus.ex_valid); end
            vectors++; if (bus.ex_instr !== add_i(1, 2, 3)) begin miscompares++; $display("FAIL st_instr[%0d]: got %h, required %h", c, bus.ex_instr, add_i(1, 2, 3)); end
            vectors++; if (bus.ex_pc !== 32'h400) begin miscompares++; $display("FAIL st_pc[%0d]: got %h, required 00000400", c, bus.ex_pc); end
            vectors++; if (bus.if_ready !== 1'b0) begin miscompares++; $display("FAIL st_if_ready[%0d]: got %b, required 0", c, bus.if_ready); end
            tick();
        end
        bus.ex_ready = 1'b1;
        push(add_i(4, 5, 6), 32'h404, 1'b0);
        samp();
        vectors++; if (bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL st_accept: got if_ready=%b, required 1", bus.if_ready); end
        tick();
        bus.if_valid = 1'b0;
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL st_next: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
    endtask

    task automatic test_illegal();
        apply_reset();
        offer(32'hFFFF_FFFF, 32'h500); push(32'hFFFF_FFFF, 32'h500, 1'b1);
        samp(); tick();
        offer(add_i(1, 31, 31), 32'h504); push(add_i(1, 31, 31), 32'h504, 1'b0);
        samp();
        vectors++; if (bus.ex_illegal !== 1'b1) begin miscompares++; $display("FAIL il_flag: got %b, required 1", bus.ex_illegal); end
        tick();
        bus.if_valid = 1'b0;
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL il_no_stall: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        offer(lw_i(5, 0), 32'h600); push(lw_i(5, 0), 32'h600, 1'b0);
        samp(); tick();
        offer(add_i(6, 5, 1), 32'h604);
        samp(); tick();
        bus.if_valid = 1'b0;
        samp();
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL ar_hazard: got ex_valid=%b, required 0", bus.ex_valid); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL ar_ex_valid: got %b, required 0", bus.ex_valid); end
        vectors++; if (bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL ar_if_ready: got %b, required 1", bus.if_ready); end
        vectors++; if (bus.dec_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL ar_dec_instr: got %h, required 00000013", bus.dec_instr); end
        vectors++; if (bus.ex_pc !== 32'h0) begin miscompares++; $display("FAIL ar_ex_pc: got %h, required 0", bus.ex_pc); end
        vectors++; if (bus.ex_illegal !== 1'b0) begin miscompares++; $display("FAIL ar_ex_illegal: got %b, required 0", bus.ex_illegal); end
        tick();
        rst = 1'b0;
        offer(add_i(6, 5, 1), 32'h608); push(add_i(6, 5, 1), 32'h608, 1'b0);
        samp(); tick();
        bus.if_valid = 1'b0;
        samp();
        vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL ar_sb_cleared: got ex_valid=%b, required 1", bus.ex_valid); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_max_loads();
        test_flush();
        test_stall();
        test_illegal();
        test_async_reset();
        repeat (2) tick();
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending issues, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
Issue controller between instruction fetch and execute. Holds one instruction in the IF/ID register, drives it into the combinational decoder, and reads back the decoded fields. It tracks outstanding load destinations in a register scoreboard and stalls on load-use hazards. It also squashes on redirect/flush and hands instructions to EX over a valid/ready handshake.

Parameters:
MAX_LOADS, 2, maximum outstanding (issued, not written back) loads; range 1..7.
PC_W, 32, program-counter width.

Ports:
clk  in  1  core clock.
rst  in  1  reset, asynchronous, active-high.
if_valid  in  1  fetch offers instruction.
if_ready  out  1  controller accepts fetch.
if_instr  in  32  fetched instruction.
if_pc  in  PC_W  its PC.
dec_instr  out  32  IF/ID instruction to decoder.
dec_opcode  in  7  decoder opcode.
dec_rs1, dec_rs2, dec_rd  in  5 each  decoder register addresses.
dec_r, dec_i, dec_s, dec_b, dec_u, dec_j  in  1 each  decoder type flags.
ex_valid  out  1  instruction issued to EX.
ex_ready  in  1  EX accepts.
ex_instr  out  32  issued instruction.
ex_pc  out  PC_W  issued PC.
ex_illegal  out  1  issued word has no type flag set.
flush  in  1  EX redirect (taken branch/jump); squash IF/ID.
ld_done  in  1  a load wrote back this cycle.
ld_rd  in  5  destination of that load.

Behaviour:
- Reset (async): id_valid=0; scoreboard=0; load count=0; if_ready=1; ex_valid=0; dec_instr=32'h0000_0013 (NOP); ex_pc=0; ex_illegal=0.
- States: EMPTY (id_valid=0), HELD (id_valid=1, no hazard), HAZARD (id_valid=1, hazard true). The state is derived from id_valid and hazard; there are no extra flops.
- if_ready = !id_valid || ex_fire || flush. ex_fire = ex_valid && ex_ready.
- Capture: when if_valid && if_ready && !flush, load the IF/ID register on the next edge (id_valid=1). Latency from fetch accept to earliest ex_valid is 1 cycle.
- Flush: id_valid=0 next edge. Any fetch accepted in the same cycle is discarded. ex_valid is forced 0 during flush. The scoreboard is unaffected.
- Source use:
  - rs1 is used for dec_r, dec_i, dec_s, dec_b.
  - rs2 is used for dec_r, dec_s, dec_b.
  - x0 never hazards.
- Hazard: a used source has its scoreboard bit set, after applying same-cycle ld_done clear (ld_done bypasses the hazard). A load (dec_opcode==7'b0000011) also hazards when count==MAX_LOADS && !ld_done.
- ex_valid = id_valid && !hazard && !flush. ex_instr, ex_pc and ex_illegal are combinational from the IF/ID register. They hold stable while ex_valid && !ex_ready (no retraction).
- Scoreboard update per edge:
  - clear bit ld_rd if ld_done.
  - set bit dec_rd if ex_fire, load, and dec_rd!=0.
  - If set and clear target the same rd in one cycle, set wins.
- Load count: +1 on load ex_fire, -1 on ld_done, unchanged when both occur. ld_done at count 0 is ignored (no underflow). Count never exceeds MAX_LOADS.
- Illegal (no type flag) still issues with ex_illegal=1 and sets no scoreboard bit.
- Reset asserted mid-stall clears everything immediately. No state survives reset.

Optional Feature:
ISSUE_PERF_CNT_EN: adds outputs perf_stall_cnt[31:0] (cycles with id_valid && hazard) and perf_issue_cnt[31:0] (ex_fire count). Both reset to 0, wrap at 2^32, and do not count during flush. Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared core package gains OPCODE_I_LOAD reuse, a NOP_INSTR constant (32'h0000_0013), and a localparam-sized load-count type.
- Sub-module load_scoreboard holds the 32-bit pending mask, the load counter, the set/clear priority and the hazard output. decode_issue_ctrl keeps the handshake/flush logic.

Test Plan:
- Back-to-back independent ADDs with ex_ready=1: one issue per cycle, ex_pc 0x0,0x4,0x8 on consecutive cycles, no stalls.
- LW x5 issued, then ADD x6,x5,x1: ADD ex_valid=0 until ld_done with ld_rd=5; issues in the same cycle ld_done asserts.
- MAX_LOADS=2: three LW to x1,x2,x3 with no ld_done: third held. One ld_done, then third issues; count stays ≤2.
- flush asserted with id_valid=1 and if_valid=1: ex_valid=0 that cycle, id_valid=0 next, fetched word dropped.
- ex_ready=0 for 3 cycles with instruction held: ex_valid, ex_instr and ex_pc stable; if_ready=0.
- Word 32'hFFFF_FFFF: issues with ex_illegal=1 and scoreboard unchanged. Async rst mid-HAZARD: all outputs at reset values before the next clk edge.
